// File: rtl/state_dump_streamer_pkg.sv
// Shared types and constants for the architectural state dump path.
// Header bytes, ASCII codes and FSM/section encodings.
package common;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        FETCH,
        BITS,
        EOL,
        FINISH
    } dump_state_t;

    typedef enum logic {
        REGS,
        MEM
    } dump_section_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_ONE  = 8'h31;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    localparam logic [0:6][7:0] REGS_HDR = {
        8'h52, 8'h45, 8'h47, 8'h53, 8'h3A, ASCII_CR, ASCII_LF
    };

    localparam logic [0:5][7:0] MEM_HDR = {
        8'h4D, 8'h45, 8'h4D, 8'h3A, ASCII_CR, ASCII_LF
    };

    function automatic logic [7:0] hdr_byte(
        input dump_section_t sec,
        input logic [2:0]    i
    );
        logic [7:0] b;
        b = 8'h00;
        if (sec == REGS) begin
            if (i < 3'd7) b = REGS_HDR[i];
        end else begin
            if (i < 3'd6) b = MEM_HDR[i];
        end
        return b;
    endfunction

    function automatic logic hdr_is_last(
        input dump_section_t sec,
        input logic [2:0]    i
    );
        return (sec == REGS) ? (i == 3'd6) : (i == 3'd5);
    endfunction

endpackage

// File: rtl/state_dump_streamer_serializer.sv
// Turns one loaded word into an ASCII binary line, MSB first, then CR LF.
// Presents one byte at a time over valid/ready; line_done on the LF accept.
module word_line_serializer
    import common::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             ready,
    output logic             valid,
    output logic [7:0]       data,
    output logic             bits_last,
    output logic             line_done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             lf_phase;
    logic             active;
    logic             accept;

    assign valid  = active;
    assign accept = active && ready;

    always_comb begin
        data = ASCII_CR;
        if (cnt != '0) begin
            data = shreg[WIDTH-1] ? ASCII_ONE : ASCII_ZERO;
        end else if (lf_phase) begin
            data = ASCII_LF;
        end
    end

    assign bits_last = accept && (cnt == CNT_W'(1));
    assign line_done = accept && (cnt == '0) && lf_phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            cnt      <= '0;
            lf_phase <= 1'b0;
            active   <= 1'b0;
        end else if (load) begin
            shreg    <= word;
            cnt      <= CNT_W'(WIDTH);
            lf_phase <= 1'b0;
            active   <= 1'b1;
        end else if (accept) begin
            if (cnt != '0) begin
                shreg <= shreg << 1;
                cnt   <= cnt - 1'b1;
            end else if (!lf_phase) begin
                lf_phase <= 1'b1;
            end else begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/state_dump_streamer.sv
// Dumps register file then data memory as ASCII binary lines to uart_tx.
// Reads state only through the read ports; one byte per accept.
module state_dump_streamer
    import common::*;
#(
    parameter int CPU_DATA_WIDTH              = 32,
    parameter int REG_COUNT                   = 32,
    parameter int REGISTER_FILE_ADDRESS_WIDTH = 5,
    parameter int MEM_WORDS                   = 32,
    parameter int DATA_ADDRESS_WIDTH          = 6
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    output logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] reg_rd_id,
    input  logic [CPU_DATA_WIDTH-1:0]              reg_rd_data,
    output logic [DATA_ADDRESS_WIDTH-1:0]          mem_rd_addr,
    input  logic [CPU_DATA_WIDTH-1:0]              mem_rd_data,
    output logic [7:0]                             tx_byte,
    output logic                                   tx_valid,
    input  logic                                   tx_ready,
    output logic                                   busy,
    output logic                                   done
);

    localparam int MAX_CNT = (REG_COUNT > MEM_WORDS) ? REG_COUNT : MEM_WORDS;
    localparam int IDX_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    dump_state_t   state, state_nx;
    dump_section_t section, section_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [2:0]       hdr_idx, hdr_idx_nx;
    logic             fetch_ph, fetch_ph_nx;

    logic                      ser_load;
    logic                      ser_valid;
    logic [7:0]                ser_byte;
    logic                      ser_bits_last;
    logic                      ser_line_done;
    logic [CPU_DATA_WIDTH-1:0] rd_word;
    logic                      idx_last;

    // Address follows the index for the whole section, so the read port
    // has a full cycle of setup before the capture cycle.
    assign reg_rd_id = (section == REGS)
        ? REGISTER_FILE_ADDRESS_WIDTH'(idx) : '0;
    assign mem_rd_addr = (section == MEM)
        ? DATA_ADDRESS_WIDTH'(idx) : '0;

    assign rd_word  = (section == REGS) ? reg_rd_data : mem_rd_data;
    assign idx_last = (section == REGS)
        ? (idx == IDX_W'(REG_COUNT - 1))
        : (idx == IDX_W'(MEM_WORDS - 1));

    word_line_serializer #(
        .WIDTH(CPU_DATA_WIDTH)
    ) u_line (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .word     (rd_word),
        .ready    (tx_ready),
        .valid    (ser_valid),
        .data     (ser_byte),
        .bits_last(ser_bits_last),
        .line_done(ser_line_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            section  <= REGS;
            idx      <= '0;
            hdr_idx  <= '0;
            fetch_ph <= 1'b0;
        end else begin
            state    <= state_nx;
            section  <= section_nx;
            idx      <= idx_nx;
            hdr_idx  <= hdr_idx_nx;
            fetch_ph <= fetch_ph_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        section_nx  = section;
        idx_nx      = idx;
        hdr_idx_nx  = hdr_idx;
        fetch_ph_nx = fetch_ph;
        tx_valid    = 1'b0;
        tx_byte     = 8'h00;
        busy        = 1'b1;
        done        = 1'b0;
        ser_load    = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx   = HEADER;
                    section_nx = REGS;
                    idx_nx     = '0;
                    hdr_idx_nx = '0;
                end
            end
            HEADER: begin
                tx_valid = 1'b1;
                tx_byte  = hdr_byte(section, hdr_idx);
                if (tx_ready) begin
                    if (hdr_is_last(section, hdr_idx)) begin
                        hdr_idx_nx  = '0;
                        fetch_ph_nx = 1'b0;
                        state_nx    = FETCH;
                    end else begin
                        hdr_idx_nx = hdr_idx + 3'd1;
                    end
                end
            end
            FETCH: begin
                if (!fetch_ph) begin
                    fetch_ph_nx = 1'b1;
                end else begin
                    ser_load    = 1'b1;
                    fetch_ph_nx = 1'b0;
                    state_nx    = BITS;
                end
            end
            BITS: begin
                tx_valid = ser_valid;
                tx_byte  = ser_byte;
                if (ser_bits_last) state_nx = EOL;
            end
            EOL: begin
                tx_valid = ser_valid;
                tx_byte  = ser_byte;
                if (ser_line_done) begin
                    if (!idx_last) begin
                        idx_nx   = idx + 1'b1;
                        state_nx = FETCH;
                    end else if (section == REGS) begin
                        section_nx = MEM;
                        idx_nx     = '0;
                        state_nx   = HEADER;
                    end else begin
                        state_nx = FINISH;
                    end
                end
            end
            FINISH: begin
                busy     = 1'b0;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
